// File: rtl/cla_bist_engine.sv
// Built-in self test for an N-bit carry-lookahead adder: two LFSRs feed the adder and a MISR compacts the results.
// Latency: start sampled at edge 0, done pulses after edge NUM_PAT+2; one pattern per clock in RUN.
// Backpressure: none; start is honoured only in IDLE, abort cancels SEED/RUN/CMP on the next edge.
//
// Ports: clk/rst (async active-low) | start, mode (0 learn, 1 test), abort, cin, fault_mask |
//        busy, done (1-cycle pulse), pass (sticky), gold_valid, signature (MISR), pat_cnt.

// Two-level lookahead adder: bit generate/propagate, 4-bit groups with
// group G/P, group carries formed directly from cin and lower group G/P,
// and in-group carries formed directly from the group carry-in.
module cla_adder #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int GS = 4;
    localparam int NG = (WIDTH + GS - 1) / GS;
    localparam int PW = NG * GS;

    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;
    logic [PW:0]   c;
    // Carries past the top operand bit fall out of the padded last group.
    logic          unused_carry_bits;

    // AND of v[lo..hi]; empty range is 1.
    function automatic logic and_range(input logic [PW-1:0] v, input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int i = lo; i <= hi; i++) begin
            r = r & v[i];
        end
        return r;
    endfunction

    // Flattened carry out of positions lo..hi given carry-in ci (sum of products, no ripple).
    function automatic logic la_carry(input logic [PW-1:0] gv, input logic [PW-1:0] pv,
                                      input int lo, input int hi, input logic ci);
        logic r;
        r = ci & and_range(pv, lo, hi);
        for (int m = lo; m <= hi; m++) begin
            r = r | (gv[m] & and_range(pv, m + 1, hi));
        end
        return r;
    endfunction

    always_comb begin
        g = '0;
        p = '0;
        g[WIDTH-1:0] = a & b;
        p[WIDTH-1:0] = a ^ b;
    end

    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int k = 0; k < NG; k++) begin
            gg[k] = la_carry(g, p, k * GS, k * GS + GS - 1, 1'b0);
            gp[k] = and_range(p, k * GS, k * GS + GS - 1);
        end
        gc[0] = cin;
        for (int k = 0; k < NG; k++) begin
            gc[k+1] = la_carry(PW'(gg), PW'(gp), 0, k, cin);
        end
        c[0] = cin;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GS; j++) begin
                c[k*GS+j+1] = la_carry(g, p, k * GS, k * GS + j, gc[k]);
            end
        end
    end

    assign sum               = p[WIDTH-1:0] ^ c[WIDTH-1:0];
    assign cout              = c[WIDTH];
    assign unused_carry_bits = ^{c, gc};
endmodule

module cla_bist_engine #(
    parameter int               WIDTH     = 6,
    parameter int               SIG_W     = 8,
    parameter int               NUM_PAT   = 14,
    parameter logic [WIDTH-1:0] SEED_A    = 6'h01,
    parameter logic [WIDTH-1:0] SEED_B    = 6'h2A,
    parameter logic [WIDTH-1:0] LFSR_POLY = 6'h21,
    parameter logic [SIG_W-1:0] MISR_POLY = 8'hB8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             cin,
    input  logic [WIDTH-1:0] fault_mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             gold_valid,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      pat_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_CMP, S_DONE} state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_A_EFF = (SEED_A == '0) ? WIDTH'(1) : SEED_A;
    localparam logic [WIDTH-1:0] SEED_B_EFF = (SEED_B == '0) ? WIDTH'(1) : SEED_B;
    localparam logic [15:0]      NUM_PAT_W  = 16'(NUM_PAT);

    state_t           state;
    logic             mode_q;
    logic [WIDTH-1:0] lfsr_a;
    logic [WIDTH-1:0] lfsr_b;
    logic [SIG_W-1:0] misr;
    logic [SIG_W-1:0] golden;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [SIG_W-1:0] s_ext;
    logic [SIG_W-1:0] misr_next;
    logic [WIDTH-1:0] lfsr_a_next;
    logic [WIDTH-1:0] lfsr_b_next;

    cla_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (lfsr_a),
        .b    (lfsr_b),
        .cin  (cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Fault injection corrupts the sum bits only; carry-out is left intact.
    assign s_ext = SIG_W'({add_cout, add_sum ^ fault_mask});

    // Right-shifting Galois MISR: bit 0 leaving the register folds the taps back in.
    assign misr_next = (misr >> 1) ^ ({SIG_W{misr[0]}} & MISR_POLY) ^ s_ext;

    // Fibonacci LFSR shifting towards the MSB; new LSB is the parity of tapped stages.
    assign lfsr_a_next = {lfsr_a[WIDTH-2:0], ^(lfsr_a & LFSR_POLY)};
    assign lfsr_b_next = {lfsr_b[WIDTH-2:0], ^(lfsr_b & LFSR_POLY)};

    assign signature = misr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            lfsr_a     <= SEED_A_EFF;
            lfsr_b     <= SEED_B_EFF;
            misr       <= '0;
            golden     <= '0;
            gold_valid <= 1'b0;
            pass       <= 1'b0;
            pat_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Abort alongside start keeps the engine idle.
                    if (start && !abort) begin
                        mode_q  <= mode;
                        pass    <= 1'b0;
                        pat_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_SEED;
                    end
                end
                S_SEED: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        lfsr_a <= SEED_A_EFF;
                        lfsr_b <= SEED_B_EFF;
                        misr   <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        misr    <= misr_next;
                        lfsr_a  <= lfsr_a_next;
                        lfsr_b  <= lfsr_b_next;
                        pat_cnt <= pat_cnt + 16'd1;
                        if (pat_cnt + 16'd1 == NUM_PAT_W) begin
                            state <= S_CMP;
                        end
                    end
                end
                S_CMP: begin
                    busy <= 1'b0;
                    if (abort) begin
                        pass  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (!mode_q) begin
                            golden     <= misr;
                            gold_valid <= 1'b1;
                            pass       <= 1'b1;
                        end else begin
                            pass <= gold_valid && (misr == golden);
                        end
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
